// File: rtl/glitch_inj_pkg.sv
// Shared definitions for the voltage-glitch injector.
//   - default parameter widths
//   - FSM state encoding (IDLE, DELAY, PULSE, GAP, FINISH)
//   - is_armed(): states in which detector alarms are recorded
package glitch_inj_pkg;

  localparam int DEF_DLY_W     = 16;
  localparam int DEF_REP_W     = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_NUM_BANKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Alarms are recorded from the start of the delay until the last pulse
  // or gap ends; IDLE and FINISH are outside the window.
  function automatic logic is_armed(input state_t s);
    return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/glitch_down_counter.sv
// Loadable down-counter with a zero flag.
//   clk_ps   : clock, posedge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val this cycle (wins over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   zero     : count is zero
module glitch_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_ps,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/glitch_injector.sv
// Programmable voltage-glitch injector with built-in alarm recording.
//   clk_ps         : clock, posedge
//   rst_n          : asynchronous active-low reset
//   start          : one-cycle strobe, accepted only in IDLE
//   abort          : ends the campaign (FINISH on next edge); ignored in IDLE
//   delay_cycles   : cycles from start to first pulse
//   width_cycles   : pulse high time (0 -> 1)
//   gap_cycles     : low time between pulses (0 -> 1)
//   repeat_count   : number of pulses (0 -> 1)
//   bank_mask      : ring-oscillator banks enabled during a pulse
//   alarm          : detector alarm (launched on negedge, consumed here)
//   ro_en          : registered bank enables
//   tdl_launch     : registered toggle source for the detector delay line
//   busy           : campaign in progress
//   done           : one-cycle pulse at campaign end
//   alarm_count    : saturating count of armed cycles with alarm high
//   first_alarm_at : elapsed cycles from start to first alarm, all-ones if none
module glitch_injector
  import glitch_inj_pkg::*;
#(
  parameter int DLY_W     = DEF_DLY_W,
  parameter int REP_W     = DEF_REP_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                 clk_ps,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DLY_W-1:0]     delay_cycles,
  input  logic [DLY_W-1:0]     width_cycles,
  input  logic [DLY_W-1:0]     gap_cycles,
  input  logic [REP_W-1:0]     repeat_count,
  input  logic [NUM_BANKS-1:0] bank_mask,
  input  logic                 alarm,
  output logic [NUM_BANKS-1:0] ro_en,
  output logic                 tdl_launch,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     alarm_count,
  output logic [CNT_W-1:0]     first_alarm_at
);

  state_t state, next_state;

  // Latched campaign configuration, stored as (value - 1) with 0 -> 1.
  logic [DLY_W-1:0]     wm1_q;
  logic [DLY_W-1:0]     gm1_q;
  logic [NUM_BANKS-1:0] mask_q;

  logic [DLY_W-1:0] w_in_m1, g_in_m1;
  logic [REP_W-1:0] r_in_m1;

  logic             tmr_load, tmr_zero;
  logic [DLY_W-1:0] tmr_val;
  logic             rep_load, rep_dec, rep_zero;

  logic                 busy_d, done_d, tdl_d;
  logic [NUM_BANKS-1:0] ro_en_d;

  logic             start_ok;
  logic             first_seen;
  logic [CNT_W-1:0] elapsed;

  assign start_ok = (state == ST_IDLE) && start;

  assign w_in_m1 = (width_cycles == '0) ? '0 : width_cycles - DLY_W'(1);
  assign g_in_m1 = (gap_cycles   == '0) ? '0 : gap_cycles   - DLY_W'(1);
  assign r_in_m1 = (repeat_count == '0) ? '0 : repeat_count - REP_W'(1);

  // Shared phase timer: loaded with (cycles - 1) on entry to DELAY, PULSE
  // or GAP; the phase ends in the cycle where it reads zero.
  glitch_down_counter #(.WIDTH(DLY_W)) u_phase_tmr (
    .clk_ps   (clk_ps),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (1'b1),
    .zero     (tmr_zero)
  );

  // Remaining pulses after the current one.
  glitch_down_counter #(.WIDTH(REP_W)) u_rep_cnt (
    .clk_ps   (clk_ps),
    .rst_n    (rst_n),
    .load     (rep_load),
    .load_val (r_in_m1),
    .dec      (rep_dec),
    .zero     (rep_zero)
  );

  // State register
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and counter control
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    rep_load   = 1'b0;
    rep_dec    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          rep_load = 1'b1;
          if (delay_cycles != '0) begin
            next_state = ST_DELAY;
            tmr_val    = delay_cycles - DLY_W'(1);
          end else begin
            next_state = ST_PULSE;
            tmr_val    = w_in_m1;
          end
        end
      end
      ST_DELAY: begin
        if (tmr_zero) begin
          next_state = ST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = wm1_q;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          if (rep_zero) begin
            next_state = ST_FINISH;
          end else begin
            next_state = ST_GAP;
            tmr_load   = 1'b1;
            tmr_val    = gm1_q;
            rep_dec    = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          next_state = ST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = wm1_q;
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    // abort overrides any in-flight phase; in IDLE start wins.
    if (abort && is_armed(state)) begin
      next_state = ST_FINISH;
    end
  end

  // Output decode. Outputs are registered, so they trail the state by one
  // cycle; ro_en is additionally gated by abort so it drops on the abort edge.
  always_comb begin
    busy_d  = (next_state != ST_IDLE) || (state == ST_FINISH);
    done_d  = (state == ST_FINISH);
    ro_en_d = ((state == ST_PULSE) && !abort) ? mask_q : '0;
    tdl_d   = busy_d ? ~tdl_launch : 1'b0;
  end

  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      ro_en      <= '0;
      tdl_launch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ro_en      <= ro_en_d;
      tdl_launch <= tdl_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Configuration latch
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      wm1_q  <= '0;
      gm1_q  <= '0;
      mask_q <= '0;
    end else if (start_ok) begin
      wm1_q  <= w_in_m1;
      gm1_q  <= g_in_m1;
      mask_q <= bank_mask;
    end
  end

  // Alarm recording. alarm arrives from a negedge flop, so it is used
  // directly here over a half-cycle path without synchronisation.
  // elapsed holds at all-ones instead of wrapping so a late first alarm
  // is never reported as an early one.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      elapsed        <= '0;
      first_seen     <= 1'b0;
      alarm_count    <= '0;
      first_alarm_at <= '1;
    end else if (start_ok) begin
      elapsed        <= '0;
      first_seen     <= 1'b0;
      alarm_count    <= '0;
      first_alarm_at <= '1;
    end else begin
      if (elapsed != '1) begin
        elapsed <= elapsed + CNT_W'(1);
      end
      if (alarm && is_armed(state)) begin
        if (alarm_count != '1) begin
          alarm_count <= alarm_count + CNT_W'(1);
        end
        if (!first_seen) begin
          first_seen     <= 1'b1;
          first_alarm_at <= elapsed;
        end
      end
    end
  end

endmodule

// File: tb/tb_glitch_injector.sv
// Directed testbench for glitch_injector. Cycle i means the interval after
// the i-th posedge following the edge that sampled start (i = 0).
module tb_glitch_injector;

  logic        clk_ps = 1'b0;
  logic        rst_n;
  logic        start, abort, alarm;
  logic [15:0] delay_cycles, width_cycles, gap_cycles;
  logic [7:0]  repeat_count;
  logic [3:0]  bank_mask;
  logic [3:0]  ro_en;
  logic        tdl_launch, busy, done;
  logic [15:0] alarm_count, first_alarm_at;

  int vectors     = 0;
  int miscompares = 0;

  glitch_injector dut (
    .clk_ps         (clk_ps),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .delay_cycles   (delay_cycles),
    .width_cycles   (width_cycles),
    .gap_cycles     (gap_cycles),
    .repeat_count   (repeat_count),
    .bank_mask      (bank_mask),
    .alarm          (alarm),
    .ro_en          (ro_en),
    .tdl_launch     (tdl_launch),
    .busy           (busy),
    .done           (done),
    .alarm_count    (alarm_count),
    .first_alarm_at (first_alarm_at)
  );

  always #5 clk_ps = ~clk_ps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_ps);
    #1;
  endtask

  task automatic launch(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                        input logic [7:0] r, input logic [3:0] m);
    delay_cycles = d;
    width_cycles = w;
    gap_cycles   = g;
    repeat_count = r;
    bank_mask    = m;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; alarm = 1'b0;
    delay_cycles = '0; width_cycles = '0; gap_cycles = '0;
    repeat_count = '0; bank_mask = '0;

    // Reset values
    tick(); tick();
    check("rst_ro_en", ro_en, 0);
    check("rst_tdl", tdl_launch, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alarm_count", alarm_count, 0);
    check("rst_first_alarm", first_alarm_at, 16'hFFFF);
    #2 rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", busy, 0);

    // Test 1: D=3 W=2 G=1 R=1 mask 0101 -> ro_en cycles 4-5, done 6
    launch(16'd3, 16'd2, 16'd1, 8'd1, 4'b0101);
    for (int i = 0; i <= 7; i++) begin
      check($sformatf("t1_ro_en[%0d]", i), ro_en, (i == 4 || i == 5) ? 32'h5 : 32'h0);
      check($sformatf("t1_done[%0d]", i), done, (i == 6) ? 32'h1 : 32'h0);
      check($sformatf("t1_busy[%0d]", i), busy, (i <= 6) ? 32'h1 : 32'h0);
      tick();
    end
    check("t1_alarm_count", alarm_count, 0);
    check("t1_first_alarm", first_alarm_at, 16'hFFFF);

    // Test 2: D=0 W=1 G=0(->1) R=3 -> pulses at cycles 1,3,5; done 6
    launch(16'd0, 16'd1, 16'd0, 8'd3, 4'b1010);
    for (int i = 0; i <= 7; i++) begin
      check($sformatf("t2_ro_en[%0d]", i), ro_en, (i == 1 || i == 3 || i == 5) ? 32'hA : 32'h0);
      check($sformatf("t2_done[%0d]", i), done, (i == 6) ? 32'h1 : 32'h0);
      check($sformatf("t2_busy[%0d]", i), busy, (i <= 6) ? 32'h1 : 32'h0);
      check($sformatf("t2_tdl[%0d]", i), tdl_launch, (i <= 6 && (i % 2 == 0)) ? 32'h1 : 32'h0);
      tick();
    end

    // Test 3: alarm high in cycles 5-6 (armed) and cycle 10 (idle, ignored)
    launch(16'd4, 16'd4, 16'd1, 8'd1, 4'b0001);
    for (int i = 0; i <= 12; i++) begin
      alarm = (i == 5 || i == 6 || i == 10);
      tick();
    end
    alarm = 1'b0;
    check("t3_alarm_count", alarm_count, 2);
    check("t3_first_alarm", first_alarm_at, 5);
    check("t3_busy_end", busy, 0);

    // Test 4: start+abort together (start wins), abort in cycle 2, abort in idle
    delay_cycles = 16'd1; width_cycles = 16'd10; gap_cycles = 16'd1;
    repeat_count = 8'd2; bank_mask = 4'b1100;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      check($sformatf("t4_ro_en[%0d]", i), ro_en, (i == 2) ? 32'hC : 32'h0);
      check($sformatf("t4_done[%0d]", i), done, (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("t4_busy[%0d]", i), busy, (i <= 4) ? 32'h1 : 32'h0);
      abort = (i == 2 || i == 6);
      tick();
    end
    abort = 1'b0;
    check("t4_alarm_count", alarm_count, 0);

    // Test 5: D=2 W=3 G=2 R=2, config changes and a second start while busy
    launch(16'd2, 16'd3, 16'd2, 8'd2, 4'b0011);
    for (int i = 0; i <= 12; i++) begin
      check($sformatf("t5_ro_en[%0d]", i), ro_en,
            ((i >= 3 && i <= 5) || (i >= 8 && i <= 10)) ? 32'h3 : 32'h0);
      check($sformatf("t5_done[%0d]", i), done, (i == 11) ? 32'h1 : 32'h0);
      check($sformatf("t5_busy[%0d]", i), busy, (i <= 11) ? 32'h1 : 32'h0);
      if (i == 1) begin
        delay_cycles = 16'd0; width_cycles = 16'd1; gap_cycles = 16'd0;
        repeat_count = 8'd5; bank_mask = 4'b1111;
      end
      start = (i == 3);
      tick();
    end
    start = 1'b0;

    // Test 6: reset mid-pulse, then a fresh campaign with W=0, R=0 (-> 1, 1)
    launch(16'd0, 16'd10, 16'd0, 8'd1, 4'b1111);
    tick(); tick(); tick();
    check("t6_ro_en_before", ro_en, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ro_en", ro_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tdl", tdl_launch, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_first_alarm", first_alarm_at, 16'hFFFF);
    #3 rst_n = 1'b1;
    launch(16'd0, 16'd0, 16'd0, 8'd0, 4'b0110);
    for (int i = 0; i <= 4; i++) begin
      check($sformatf("t6_ro_en[%0d]", i), ro_en, (i == 1) ? 32'h6 : 32'h0);
      check($sformatf("t6_done[%0d]", i), done, (i == 2) ? 32'h1 : 32'h0);
      check($sformatf("t6_busy[%0d]", i), busy, (i <= 2) ? 32'h1 : 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
